// File: rtl/tone_burst_gen.sv
// Test-signal source: square or bounded-triangle samples at a programmable rate,
// gated by an optional on/off burst envelope, for the level-measurement path.
module tone_burst_gen (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               wave_sel,
  input  logic [15:0]        sample_period,
  input  logic [14:0]        amplitude,
  input  logic [7:0]         half_cycle,
  input  logic [14:0]        tri_step,
  input  logic [9:0]         burst_on,
  input  logic [9:0]         burst_off,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               burst_active
);

  localparam int unsigned RW = 16;
  localparam int unsigned HW = 8;
  localparam int unsigned BW = 10;
  localparam int unsigned SW = 16;
  localparam int unsigned XW = 17;

  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_t;

  logic [RW-1:0]        rate_cnt, rate_cnt_n;
  logic [HW-1:0]        h, h_n;
  logic                 pol, pol_n;
  logic signed [SW-1:0] tri_val, tri_val_n;
  logic                 dir_up, dir_up_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  phase_t               ph, ph_n;
  logic signed [SW-1:0] out_n;
  logic                 valid_n, active_n;

  logic [RW-1:0]        period_m1;
  logic [HW-1:0]        half_m1;
  logic [BW-1:0]        on_m1, off_m1;
  logic                 tick;
  logic signed [XW-1:0] amp_x, neg_amp_x, tri_x, step_x, sum_x;
  logic signed [SW-1:0] wave;

  // State and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_cnt     <= '0;
      h            <= '0;
      pol          <= 1'b0;
      tri_val      <= '0;
      dir_up       <= 1'b1;
      bcnt         <= '0;
      ph           <= PH_ON;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      rate_cnt     <= rate_cnt_n;
      h            <= h_n;
      pol          <= pol_n;
      tri_val      <= tri_val_n;
      dir_up       <= dir_up_n;
      bcnt         <= bcnt_n;
      ph           <= ph_n;
      sample_out   <= out_n;
      sample_valid <= valid_n;
      burst_active <= active_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    rate_cnt_n = rate_cnt;
    h_n        = h;
    pol_n      = pol;
    tri_val_n  = tri_val;
    dir_up_n   = dir_up;
    bcnt_n     = bcnt;
    ph_n       = ph;
    out_n      = sample_out;
    valid_n    = 1'b0;
    active_n   = burst_active;

    period_m1 = (sample_period == '0) ? '0 : RW'(sample_period - RW'(1));
    half_m1   = (half_cycle == '0) ? '0 : HW'(half_cycle - HW'(1));
    on_m1     = (burst_on == '0) ? '0 : BW'(burst_on - BW'(1));
    off_m1    = (burst_off == '0) ? '0 : BW'(burst_off - BW'(1));
    tick      = enable && (rate_cnt >= period_m1);

    amp_x     = $signed({2'b00, amplitude});
    neg_amp_x = -amp_x;
    tri_x     = XW'(tri_val);
    step_x    = $signed({2'b00, tri_step});
    sum_x     = dir_up ? (tri_x + step_x) : (tri_x - step_x);
    wave      = wave_sel ? tri_val : (pol ? SW'(neg_amp_x) : SW'(amp_x));

    if (!enable) begin
      rate_cnt_n = '0;
      h_n        = '0;
      pol_n      = 1'b0;
      tri_val_n  = '0;
      dir_up_n   = 1'b1;
      bcnt_n     = '0;
      ph_n       = PH_ON;
      out_n      = '0;
      active_n   = 1'b0;
    end else begin
      rate_cnt_n = tick ? '0 : RW'(rate_cnt + RW'(1));
      if (tick) begin
        valid_n  = 1'b1;
        active_n = (ph == PH_ON);
        out_n    = (ph == PH_ON) ? wave : '0;

        // Square phase: wraps also when H was lowered below h
        if (h >= half_m1) begin
          h_n   = '0;
          pol_n = ~pol;
        end else begin
          h_n = HW'(h + HW'(1));
        end

        // Triangle: out-of-range values snap to the nearer bound first
        if (tri_x > amp_x) begin
          tri_val_n = SW'(amp_x);
          dir_up_n  = 1'b0;
        end else if (tri_x < neg_amp_x) begin
          tri_val_n = SW'(neg_amp_x);
          dir_up_n  = 1'b1;
        end else if (dir_up && (sum_x >= amp_x)) begin
          tri_val_n = SW'(amp_x);
          dir_up_n  = 1'b0;
        end else if (!dir_up && (sum_x <= neg_amp_x)) begin
          tri_val_n = SW'(neg_amp_x);
          dir_up_n  = 1'b1;
        end else begin
          tri_val_n = SW'(sum_x);
        end

        // Burst envelope
        if (ph == PH_ON) begin
          if (burst_off == '0) begin
            bcnt_n = '0;
          end else if (bcnt >= on_m1) begin
            bcnt_n = '0;
            ph_n   = PH_OFF;
          end else begin
            bcnt_n = BW'(bcnt + BW'(1));
          end
        end else begin
          if ((burst_off == '0) || (bcnt >= off_m1)) begin
            bcnt_n = '0;
            ph_n   = PH_ON;
          end else begin
            bcnt_n = BW'(bcnt + BW'(1));
          end
        end
      end
    end
  end

endmodule
